// File: rtl/dram_wr_arbiter.sv
// Round-robin write arbiter in front of a 2^AW x DW RAM with registered read port.
// Define DRAM_ARB_INIT_EN to clear the RAM with a write sweep after reset; otherwise RUN is entered at once.
module dram_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 6,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_waddr,
    output logic [DW-1:0]        ram_di,
    output logic [AW-1:0]        ram_raddr,
    input  logic [DW-1:0]        ram_do,
    output logic                 init_done,
    output logic [15:0]          wr_count
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = PW + 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic            gvalid;
    logic [CW-1:0]   cand;
    logic            xfer;
`ifdef DRAM_ARB_INIT_EN
    logic [AW-1:0]   sweep;
`endif

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gvalid = 1'b0;
        gidx   = '0;
        cand   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
            if (!gvalid && req_valid[cand[PW-1:0]]) begin
                gvalid = 1'b1;
                gidx   = cand[PW-1:0];
            end
        end
    end

    assign xfer = (state == RUN) && gvalid;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[gidx] = 1'b1;
    end

    assign ram_raddr = rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            ptr       <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_di    <= '0;
            wr_count  <= '0;
            init_done <= 1'b0;
`ifdef DRAM_ARB_INIT_EN
            sweep     <= '0;
`endif
        end else begin
            ram_we <= 1'b0;
            case (state)
                INIT: begin
`ifdef DRAM_ARB_INIT_EN
                    ram_we    <= 1'b1;
                    ram_waddr <= sweep;
                    ram_di    <= '0;
                    sweep     <= sweep + 1'b1;
                    if (sweep == '1) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
`else
                    state     <= RUN;
                    init_done <= 1'b1;
`endif
                end
                RUN: begin
                    if (xfer) begin
                        ram_we    <= 1'b1;
                        ram_waddr <= req_addr[gidx*AW +: AW];
                        ram_di    <= req_data[gidx*DW +: DW];
                        ptr       <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= ram_do;
    end

endmodule
